// File: rtl/and3_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : and3_arbiter_if
// Brief    : Requester/consumer bundle for the shared 3-input AND arbiter.
// Revision : 1.0
// ============================================================================
interface and3_arbiter_if #(
    parameter int NREQ = 3,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] op;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic              res_out;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic              busy;

    modport master (
        output req, op, res_ready,
        input  gnt, res_valid, res_out, res_id, busy
    );

    modport slave (
        input  req, op, res_ready,
        output gnt, res_valid, res_out, res_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/and3_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : and3_arbiter
// Brief    : Round-robin arbiter sequencing NREQ requesters onto one a&b&c unit.
// Revision : 1.0
// ============================================================================
module and3_arbiter #(
    parameter int NREQ = 3,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    and3_arbiter_if.slave bus
);
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_eval = 2'd1;
    localparam logic [1:0] c_hold = 2'd2;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_ptr;
    logic [2:0]      r_opnd;
    logic [IDW-1:0]  r_win;
    logic [NREQ-1:0] r_gnt;
    logic            r_valid;
    logic            r_out;
    logic [IDW-1:0]  r_id;

    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_winner;
    logic [2:0]      w_opsel;
    logic [NREQ-1:0] w_gnt_oh;

    // Rotate requests so bit 0 is the requester at the pointer; the lowest
    // set bit of the rotated vector is then the round-robin winner offset.
    assign w_rot = NREQ'({bus.req, bus.req} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
            end
        end
    end

    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_winner = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ))
                                                : IDW'(w_sum);
    assign w_gnt_oh = NREQ'(1) << w_winner;

    always_comb begin
        w_opsel = 3'b000;
        for (int j = 0; j < NREQ; j++) begin
            if (w_winner == IDW'(j)) begin
                w_opsel = bus.op[3*j +: 3];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_ptr   <= '0;
            r_opnd  <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_out   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                c_idle: begin
                    if (|bus.req) begin
                        r_opnd  <= w_opsel;
                        r_win   <= w_winner;
                        r_gnt   <= w_gnt_oh;
                        r_state <= c_eval;
                    end
                end
                c_eval: begin
                    r_out   <= &r_opnd;
                    r_id    <= r_win;
                    r_valid <= 1'b1;
                    r_state <= c_hold;
                end
                c_hold: begin
                    if (bus.res_ready) begin
                        r_valid <= 1'b0;
                        r_ptr   <= (r_win == IDW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.res_valid = r_valid;
    assign bus.res_out   = r_out;
    assign bus.res_id    = r_id;
    assign bus.busy      = (r_state != c_idle);
endmodule
`default_nettype wire
